// File: rtl/vend_pkg.sv
// vend_pkg: state encoding and coin values shared by the coin front end and the seller stage.
package vend_pkg;
  typedef enum logic {ST_IDLE, ST_LOCK} vend_state_t;
  localparam int COIN_05 = 1;
  localparam int COIN_10 = 2;
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: 2-flop synchroniser, debounce counter and registered rising-edge detect for one coin line.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  logic [1:0] r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic r_level;
  logic r_prev;
  logic r_rise;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_level <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw};
      r_prev <= r_level;
      r_rise <= r_level & ~r_prev;
      // any sample matching the accepted level restarts the stability count
      if (r_sync[1] == r_level)
        r_cnt <= '0;
      else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt <= '0;
      end else
        r_cnt <= r_cnt + 1'b1;
    end
  end
  assign level = r_level;
  assign rise = r_rise;
endmodule

// File: rtl/coin_pulse_conditioner.sv
// coin_pulse_conditioner: turns raw coin sensor lines into exclusive d1/d2/reject pulses with post-coin lockout.
module coin_pulse_conditioner
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic coin5_raw,
  input  logic coin10_raw,
  input  logic accept_en,
  output logic d1,
  output logic d2,
  output logic reject,
  output logic locked
);
  vend_state_t r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic r_d1, r_d2, r_rej;
  logic w_d1_nx, w_d2_nx, w_rej_nx;
  logic w_rise5, w_rise10, w_lvl5, w_lvl10;
  logic w_idle, w_last, w_any, w_both;
  logic w_unused;
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb5 (
    .clk(clk), .rst(rst), .raw(coin5_raw), .level(w_lvl5), .rise(w_rise5)
  );
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb10 (
    .clk(clk), .rst(rst), .raw(coin10_raw), .level(w_lvl10), .rise(w_rise10)
  );
  assign w_unused = w_lvl5 ^ w_lvl10;
  always_comb begin
    w_any = w_rise5 | w_rise10;
    w_both = w_rise5 & w_rise10;
    w_idle = (r_state == ST_IDLE);
    w_last = (r_cnt == CNT_W'(LOCKOUT_CYCLES - 1));
    w_d1_nx = w_idle & w_rise5 & ~w_rise10 & accept_en;
    w_d2_nx = w_idle & w_rise10 & ~w_rise5 & accept_en;
    // during lockout every event is returned; lockout length is not extended by it
    w_rej_nx = w_idle ? (w_both | (w_any & ~accept_en)) : w_any;
    w_state_nx = w_idle ? (w_any ? ST_LOCK : ST_IDLE) : (w_last ? ST_IDLE : ST_LOCK);
    w_cnt_nx = (w_idle | w_last) ? '0 : r_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_d1 <= 1'b0;
      r_d2 <= 1'b0;
      r_rej <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_d1 <= w_d1_nx;
      r_d2 <= w_d2_nx;
      r_rej <= w_rej_nx;
    end
  end
  assign d1 = r_d1;
  assign d2 = r_d2;
  assign reject = r_rej;
  assign locked = (r_state == ST_LOCK);
endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// tb_coin_pulse_conditioner: table vectors, directed corner sequences and randomized traffic against a reference model.
module tb_coin_pulse_conditioner;
  localparam int DB = 4;
  localparam int LK = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic coin5_raw = 1'b0;
  logic coin10_raw = 1'b0;
  logic accept_en = 1'b1;
  logic d1, d2, reject, locked;
  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  logic [63:0] h_d1, h_d2, h_rj, h_lk;
  // reference model: sync pipeline, window of last DB synced samples, level, rise, lockout edges left
  bit [1:0] m_s1, m_s2, m_lv, m_lvp, m_rise;
  bit [DB-1:0] m_hist [2];
  int m_left;
  bit m_d1, m_d2, m_rj;
  typedef struct {
    logic c5, c10, en, rn;
    logic e_d1, e_d2, e_rj, e_lk;
  } vec_t;
  vec_t tv [12];

  always #5 clk = ~clk;

  coin_pulse_conditioner #(.DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(LK), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
    .accept_en(accept_en), .d1(d1), .d2(d2), .reject(reject), .locked(locked)
  );

  task automatic model_edge(input bit c5, input bit c10, input bit en, input bit rn);
    bit [1:0] c;
    bit [DB-1:0] w;
    bit was_locked, any, both;
    c = {c10, c5};
    if (!rn) begin
      m_s1 = 0; m_s2 = 0; m_lv = 0; m_lvp = 0; m_rise = 0;
      m_hist[0] = '0; m_hist[1] = '0;
      m_left = 0; m_d1 = 0; m_d2 = 0; m_rj = 0;
    end else begin
      was_locked = m_left > 0;
      any = m_rise[0] | m_rise[1];
      both = m_rise[0] & m_rise[1];
      m_d1 = 0; m_d2 = 0; m_rj = 0;
      if (was_locked) m_rj = any;
      else if (both) m_rj = 1;
      else if (any && !en) m_rj = 1;
      else if (any) begin m_d1 = m_rise[0]; m_d2 = m_rise[1]; end
      if (was_locked) m_left--;
      else if (any) m_left = LK;
      for (int l = 0; l < 2; l++) begin
        m_rise[l] = m_lv[l] & ~m_lvp[l];
        w = {m_hist[l][DB-2:0], m_s2[l]};
        m_lvp[l] = m_lv[l];
        if (m_lv[l] ? (w == '0) : (w == '1)) m_lv[l] = ~m_lv[l];
        m_hist[l] = w;
        m_s2[l] = m_s1[l];
        m_s1[l] = c[l];
      end
    end
  endtask

  task automatic cmp(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %b, expected %b", nm, edge_n, act, exp);
    end
  endtask

  task automatic cmp64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic c5, input logic c10, input logic en, input logic rn);
    coin5_raw = c5; coin10_raw = c10; accept_en = en; rst = rn;
    @(posedge clk);
    model_edge(c5, c10, en, rn);
    @(negedge clk);
    cmp("d1", d1, m_d1);
    cmp("d2", d2, m_d2);
    cmp("reject", reject, m_rj);
    cmp("locked", locked, m_left > 0);
    if (edge_n < 64) begin
      h_d1[edge_n] = d1; h_d2[edge_n] = d2; h_rj[edge_n] = reject; h_lk[edge_n] = locked;
    end
    edge_n++;
  endtask

  task automatic begin_test();
    step(0, 0, 1, 0);
    edge_n = 0;
    h_d1 = '0; h_d2 = '0; h_rj = '0; h_lk = '0;
  endtask

  initial begin
    int r5, r10;
    logic v5, v10;
    for (int i = 0; i < 12; i++)
      tv[i] = '{c5: i < 10, c10: 1'b0, en: 1'b1, rn: 1'b1,
                e_d1: i == 7, e_d2: 1'b0, e_rj: 1'b0, e_lk: i >= 7 && i <= 9};
    @(negedge clk);
    step(0, 0, 1, 0);
    cmp("reset_d1", d1, 1'b0);
    cmp("reset_d2", d2, 1'b0);
    cmp("reset_reject", reject, 1'b0);
    cmp("reset_locked", locked, 1'b0);
    // single accepted 0.5 coin from the table
    begin_test();
    for (int i = 0; i < 12; i++) begin
      step(tv[i].c5, tv[i].c10, tv[i].en, tv[i].rn);
      edge_n--;
      cmp("tv_d1", d1, tv[i].e_d1);
      cmp("tv_d2", d2, tv[i].e_d2);
      cmp("tv_reject", reject, tv[i].e_rj);
      cmp("tv_locked", locked, tv[i].e_lk);
      edge_n++;
    end
    // bouncing 1.0 coin then stable run starting at edge 4
    begin_test();
    for (int i = 0; i < 22; i++) step(0, (i < 4) ? logic'(~i[0]) : logic'(i < 14), 1, 1);
    cmp64("bounce_d2", h_d2, 64'h1 << 11);
    cmp64("bounce_d1", h_d1, '0);
    cmp64("bounce_rj", h_rj, '0);
    // both lines together
    begin_test();
    for (int i = 0; i < 22; i++) step(i < 6, i < 6, 1, 1);
    cmp64("both_rj", h_rj, 64'h1 << 7);
    cmp64("both_d1", h_d1, '0);
    cmp64("both_d2", h_d2, '0);
    // second coin arriving during lockout
    begin_test();
    for (int i = 0; i < 22; i++) step(i < 10, i >= 2 && i < 10, 1, 1);
    cmp64("lock_d1", h_d1, 64'h1 << 7);
    cmp64("lock_rj", h_rj, 64'h1 << 9);
    cmp64("lock_d2", h_d2, '0);
    cmp64("lock_lk", h_lk, 64'h380);
    // accept disabled
    begin_test();
    for (int i = 0; i < 22; i++) step(0, i < 8, 0, 1);
    cmp64("dis_rj", h_rj, 64'h1 << 7);
    cmp64("dis_d2", h_d2, '0);
    // reset in the middle of debounce
    begin_test();
    for (int i = 0; i < 22; i++) step(i < 20, 0, 1, i != 5);
    cmp64("rst_d1", h_d1, 64'h1 << 13);
    cmp64("rst_rj", h_rj, '0);
    cmp64("rst_lk", h_lk, 64'hE000);
    // randomized traffic against the model
    r5 = 0; r10 = 0; v5 = 0; v10 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (r5 == 0) begin v5 = ~v5; r5 = $urandom_range(1, 12); end
      if (r10 == 0) begin v10 = ~v10; r10 = $urandom_range(1, 12); end
      r5--; r10--;
      step(v5, v10, $urandom_range(0, 4) != 0, $urandom_range(0, 199) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
